mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined CPU.
- Sequences each memory transaction with a req/ack handshake.
- Arbitrates data over fetch, with a starvation guard.
- Drives stall_o into the hazard/stall logic and honours branch flushes by squashing in-flight fetches.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF
// (fetch) and MEM (load/store) stages. Data accesses win over fetches, except
// that after MAX_DM_RUN back-to-back data grants with a fetch waiting, one
// fetch is forced through. A busy timeout aborts a hung access and raises a
// sticky error_o.
// Optional build macro MEM_ARB_PERF_EN adds stall_cnt_o / squash_cnt_o.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              error_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       squash_cnt_o
`endif
);

  localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t           state, state_d;
  logic [RUN_W-1:0] run_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             kill;
  logic             forced, grant_dm, grant_if, acked, expired;
  logic             if_done, dm_done, kill_now;

  // Next-state: grant from IDLE, complete on ack or on timeout expiry
  always_comb begin
    state_d  = state;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    acked    = 1'b0;
    expired  = 1'b0;
    forced   = if_req_i && (run_cnt == RUN_W'(MAX_DM_RUN));
    case (state)
      IDLE: begin
        if (start_i) begin
          if (dm_req_i && !forced) begin
            grant_dm = 1'b1;
            state_d  = BUSY_DM;
          end else if (if_req_i) begin
            grant_if = 1'b1;
            state_d  = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i) begin
          acked   = 1'b1;
          state_d = IDLE;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          expired = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush in the completing cycle itself also squashes the fetch
  assign kill_now = kill | flush_i;
  assign if_done  = (acked | expired) && (state == BUSY_IF);
  assign dm_done  = (acked | expired) && (state == BUSY_DM);
  assign stall_o  = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_d;
  end

  // Memory port: latch the winner's request at grant, hold until completion
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (grant_dm) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= dm_we_i;
      mem_addr_o  <= dm_addr_i;
      mem_wdata_o <= dm_wdata_i;
    end else if (grant_if) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
    end else if (acked || expired) begin
      mem_req_o   <= 1'b0;
    end
  end

  // Fetch response: pulse unless squashed; data only updates on a real ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_ready_o <= 1'b0;
      if_rdata_o <= '0;
    end else begin
      if_ready_o <= if_done && !kill_now;
      if (if_done && !kill_now && acked) if_rdata_o <= mem_rdata_i;
    end
  end

  // Data response: always pulses; only a completed load updates rdata
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dm_ready_o <= 1'b0;
      dm_rdata_o <= '0;
    end else begin
      dm_ready_o <= dm_done;
      if (dm_done && acked && !mem_we_o) dm_rdata_o <= mem_rdata_i;
    end
  end

  // Starvation guard: count data grants taken while a fetch was waiting
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        run_cnt <= '0;
    else if (grant_if) run_cnt <= '0;
    else if (grant_dm) run_cnt <= if_req_i ? run_cnt + RUN_W'(1) : '0;
  end

  // Busy-cycle counter for the ack timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                to_cnt <= '0;
    else if (state != IDLE && state_d != IDLE) to_cnt <= to_cnt + TO_W'(1);
    else                                       to_cnt <= '0;
  end

  // Kill flag lives only while the fetch it squashes is in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) kill <= 1'b0;
    else        kill <= (state_d == BUSY_IF) && kill_now;
  end

  // Sticky timeout error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       error_o <= 1'b0;
    else if (expired) error_o <= 1'b1;
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating performance counters, active only while start_i is high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      squash_cnt_o <= '0;
    end else if (start_i) begin
      if (stall_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (if_done && kill_now && squash_cnt_o != '1)
        squash_cnt_o <= squash_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single transactions, hand sequences
// for contention / starvation / reset-mid-op, then random traffic checked
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int MAXRUN = 4;
  localparam int TMO    = 16;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, flush_i = 1'b0;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
  logic        if_ready_o, dm_ready_o, mem_req_o, mem_we_o, stall_o, error_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_RUN(MAXRUN), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory device ----------------
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  bit mem_en = 1'b1, rand_lat = 1'b0;
  int fix_lat = 1, cur_lat = 0, mwait = 0;

  function automatic int wi(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  // Acks cur_lat cycles after first seeing mem_req_o (-1 = never)
  task automatic mem_drive();
    if (!mem_en) return;
    if (mem_ack_i || !mem_req_o) begin
      mem_ack_i = 1'b0;
      mwait = 0;
    end else begin
      if (mwait == 0)
        cur_lat = !rand_lat ? fix_lat :
                  ($urandom_range(0, 31) == 0) ? -1 : int'($urandom_range(0, 3));
      if (cur_lat >= 0 && mwait == cur_lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) mem[wi(mem_addr_o)] = mem_wdata_o;
        mem_rdata_i = mem_we_o ? $urandom : mem[wi(mem_addr_o)];
      end else begin
        mwait++;
        mem_rdata_i = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    mem_drive();
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
    dm_we_i = 1'b0; mem_ack_i = 1'b0; mwait = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1;
  endtask

  // ---------------- table of single transactions ----------------
  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          flush_at;
    int          e_pulses;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_reqcyc;
    bit          e_err;
  } vec_t;

  task automatic run_vec(input int n, input vec_t v);
    int pulses = 0, lat = -1, reqcyc = 0;
    logic [31:0] ga = '0, gwd = '0;
    logic gwe = 1'b0, st_rdy = 1'b0, rdy;
    fix_lat = v.lat;
    if (v.dm) begin
      dm_req_i = 1'b1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    flush_i = (v.flush_at == 0);
    for (int t = 1; t <= 24; t++) begin
      tick();
      flush_i = 1'b0;
      if (mem_req_o) begin
        if (reqcyc == 0) begin ga = mem_addr_o; gwe = mem_we_o; gwd = mem_wdata_o; end
        reqcyc++;
      end
      rdy = v.dm ? dm_ready_o : if_ready_o;
      if (rdy) begin
        pulses++;
        if (lat < 0) begin lat = t; st_rdy = stall_o; end
        if (v.dm) dm_req_i = 1'b0; else if_req_i = 1'b0;
      end
      if (t == v.flush_at) flush_i = 1'b1;
      if (t == v.flush_at + 1) if_req_i = 1'b0;
    end
    chk($sformatf("v%0d_pulses", n), pulses, v.e_pulses);
    chk($sformatf("v%0d_rdata", n), v.dm ? dm_rdata_o : if_rdata_o, v.e_rdata);
    chk($sformatf("v%0d_latency", n), lat, v.e_lat);
    chk($sformatf("v%0d_reqcycles", n), reqcyc, v.e_reqcyc);
    chk($sformatf("v%0d_addr", n), ga, v.addr);
    chk($sformatf("v%0d_we", n), gwe, v.we);
    if (v.we) chk($sformatf("v%0d_wdata", n), gwd, v.wdata);
    chk($sformatf("v%0d_error", n), error_o, v.e_err);
    chk($sformatf("v%0d_stall_at_ready", n), st_rdy, 1'b0);
  endtask

  // ---------------- random-traffic reference model ----------------
  bit          m_busy, m_isdm, m_we, m_killed, m_done, e_ifr, e_dmr, e_err;
  int          m_cnt, m_run;
  logic [31:0] m_addr, m_wdata, e_ifd, e_dmd;
  logic        p_start, p_flush, p_if, p_dm, p_we, p_ack;
  logic [31:0] p_ifa, p_dma, p_wd, p_rd;

  task automatic model_step();
    e_ifr = 1'b0; e_dmr = 1'b0;
    if (m_busy) begin
      if (!m_isdm && p_flush) m_killed = 1'b1;
      m_done = p_ack;
      if (!p_ack) begin
        m_cnt++;
        if (m_cnt == TMO) begin m_done = 1'b1; e_err = 1'b1; end
      end
      if (m_done) begin
        m_busy = 1'b0;
        if (m_isdm) begin
          e_dmr = 1'b1;
          if (p_ack && m_we) shadow[wi(m_addr)] = m_wdata;
          if (p_ack && !m_we) e_dmd = shadow[wi(m_addr)];
        end else if (!m_killed) begin
          e_ifr = 1'b1;
          if (p_ack) e_ifd = shadow[wi(m_addr)];
        end
      end
    end else if (p_start && (p_if || p_dm)) begin
      m_busy = 1'b1; m_cnt = 0; m_killed = 1'b0;
      if (p_dm && !(p_if && m_run == MAXRUN)) begin
        m_isdm = 1'b1; m_we = p_we; m_addr = p_dma; m_wdata = p_wd;
        m_run = p_if ? m_run + 1 : 0;
      end else begin
        m_isdm = 1'b0; m_we = 1'b0; m_addr = p_ifa; m_killed = p_flush;
        m_run = 0;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t vt [8];
  int   first_a, dmr_t, ifg_t, gn, dmd;
  logic [5:0] gseq;
  logic prev_req;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'd5; mem[2] = 32'h00A0_0093; mem[3] = 32'h1234_5678;

    //          dm    we    addr    wdata         lat flush pulses rdata        lat  req err
    vt[0] = '{1'b0, 1'b0, 32'h8, 32'h0,          1, -1, 1, 32'h00A0_0093,  3,  2, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h0, 32'h0,          1, -1, 1, 32'd5,          3,  2, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF,  0, -1, 1, 32'd5,          2,  1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h4, 32'h0,          2, -1, 1, 32'hDEAD_BEEF,  4,  3, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'h8, 32'h0,          3,  2, 0, 32'h00A0_0093, -1,  4, 1'b0};
    vt[5] = '{1'b0, 1'b0, 32'hC, 32'h0,          1, -1, 1, 32'h1234_5678,  3,  2, 1'b0};
    vt[6] = '{1'b0, 1'b0, 32'h8, 32'h0,          1,  0, 0, 32'h1234_5678, -1,  2, 1'b0};
    vt[7] = '{1'b1, 1'b0, 32'h0, 32'h0,         -1, -1, 1, 32'hDEAD_BEEF, 17, 16, 1'b1};

    // reset state
    #3;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_ready", {if_ready_o, dm_ready_o}, 2'b00);
    chk("rst_rdata", if_rdata_o | dm_rdata_o, 32'h0);
    chk("rst_mem_port", mem_addr_o | mem_wdata_o | 32'(mem_we_o), 32'h0);
    chk("rst_err_stall", {error_o, stall_o}, 2'b00);
    reset_dut();

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);
    chk("error_sticky", error_o, 1'b1);

    // contention: load wins, fetch granted right after the data ready cycle
    reset_dut();
    chk("error_cleared", error_o, 1'b0);
    fix_lat = 1;
    if_req_i = 1'b1; if_addr_i = 32'h8; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0;
    first_a = -1; dmr_t = -1; ifg_t = -1; dmd = -1; prev_req = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (mem_req_o && !prev_req) begin
        if (first_a < 0) first_a = int'(mem_addr_o);
        if (mem_addr_o == 32'h8 && ifg_t < 0) ifg_t = t;
      end
      if (dm_ready_o) begin dmr_t = t; dmd = int'(dm_rdata_o); dm_req_i = 1'b0; end
      if (if_ready_o) if_req_i = 1'b0;
      prev_req = mem_req_o;
    end
    chk("cont_first_grant", first_a, 32'h0);
    chk("cont_dm_rdata", dmd, 32'd5);
    chk("cont_dm_ready_cycle", dmr_t, 32'd3);
    chk("cont_if_grant_cycle", ifg_t, 32'd4);

    // starvation guard: DM,DM,DM,DM,IF,DM
    reset_dut();
    if_req_i = 1'b1; if_addr_i = 32'h8;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10;
    gn = 0; gseq = '0; prev_req = 1'b0;
    for (int t = 1; t <= 80 && gn < 6; t++) begin
      tick();
      if (mem_req_o && !prev_req) begin
        gseq[gn] = (mem_addr_o == 32'h8);
        gn++;
      end
      if (dm_ready_o) dm_addr_i = 32'h10 + ((dm_addr_i + 32'h4) & 32'h2C);
      if (if_ready_o) if_req_i = 1'b0;
      prev_req = mem_req_o;
    end
    chk("starve_grants", gn, 32'd6);
    chk("starve_order", gseq, 6'b010000);
    dm_req_i = 1'b0; if_req_i = 1'b0;

    // reset in the middle of a data access; late ack must be ignored
    reset_dut();
    mem_en = 1'b0;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0;
    tick();
    chk("rmid_busy", mem_req_o, 1'b1);
    dm_req_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("rmid_mem_req", mem_req_o, 1'b0);
    chk("rmid_mem_addr", mem_addr_o, 32'h0);
    chk("rmid_outs", {dm_ready_o, if_ready_o, error_o, stall_o}, 4'b0000);
    tick();
    rst_i = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    for (int t = 0; t < 3; t++) begin
      tick();
      mem_ack_i = 1'b0;
      chk("rmid_late_ack", {dm_ready_o, if_ready_o, mem_req_o}, 3'b000);
      chk("rmid_rdata", dm_rdata_o, 32'h0);
    end
    mem_en = 1'b1;

    // random traffic against the model
    reset_dut();
    rand_lat = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = mem[i];
    m_busy = 1'b0; m_isdm = 1'b0; m_we = 1'b0; m_killed = 1'b0; m_cnt = 0; m_run = 0;
    m_addr = '0; m_wdata = '0; e_ifd = '0; e_dmd = '0; e_err = 1'b0;
    p_start = start_i; p_flush = 1'b0; p_if = 1'b0; p_dm = 1'b0; p_we = 1'b0; p_ack = 1'b0;
    p_ifa = '0; p_dma = '0; p_wd = '0; p_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      model_step();
      chk("rnd_mem_req", mem_req_o, m_busy);
      if (m_busy) begin
        chk("rnd_mem_addr", mem_addr_o, m_addr);
        chk("rnd_mem_we", mem_we_o, m_we);
        if (m_we) chk("rnd_mem_wdata", mem_wdata_o, m_wdata);
      end
      chk("rnd_ready", {if_ready_o, dm_ready_o}, {e_ifr, e_dmr});
      chk("rnd_if_rdata", if_rdata_o, e_ifd);
      chk("rnd_dm_rdata", dm_rdata_o, e_dmd);
      chk("rnd_error", error_o, e_err);
      chk("rnd_stall", stall_o, (p_if & ~e_ifr) | (p_dm & ~e_dmr));
      // requesters: hold until ready (or flush for IF), then maybe issue anew
      if (if_ready_o || flush_i) if_req_i = 1'b0;
      if (!if_req_i && $urandom_range(0, 1) == 1) begin
        if_req_i = 1'b1; if_addr_i = 32'($urandom_range(0, 15)) << 2;
      end
      flush_i = ($urandom_range(0, 9) == 0);
      if (dm_ready_o) dm_req_i = 1'b0;
      if (!dm_req_i && $urandom_range(0, 1) == 1) begin
        dm_req_i = 1'b1; dm_we_i = $urandom_range(0, 1) == 1;
        dm_addr_i = 32'($urandom_range(0, 15)) << 2; dm_wdata_i = $urandom;
      end
      start_i = ($urandom_range(0, 15) != 0);
      p_start = start_i; p_flush = flush_i; p_if = if_req_i; p_dm = dm_req_i;
      p_we = dm_we_i; p_ack = mem_ack_i; p_ifa = if_addr_i; p_dma = dm_addr_i;
      p_wd = dm_wdata_i; p_rd = mem_rdata_i;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
